// File: rtl/axi_rd_arbiter_if.sv
// Bus bundle for the two-requester AXI4 read arbiter.
//
// Carries the per-requester AR/R channels (rq_*; two-bit vectors and packed
// {requester 1, requester 0} fields) and the single shared master-side AR/R
// channel (m_*). Signal suffixes follow the arbiter's point of view.
//
// Modports:
//   slave  - the arbiter itself (accepts requester ARs, drives the master bus)
//   master - the surrounding agents: cache requesters plus the NoC adapter
interface axi_rd_arbiter_if #(
    parameter int AddrWidth = 64,
    parameter int IdWidth   = 4,
    parameter int DataWidth = 64
);
    logic [1:0]                 rq_ar_valid_i;
    logic [1:0]                 rq_ar_ready_o;
    logic [2*AddrWidth-1:0]     rq_ar_addr_i;
    logic [2*(IdWidth-1)-1:0]   rq_ar_id_i;
    logic [15:0]                rq_ar_len_i;
    logic [1:0]                 rq_r_valid_o;
    logic [1:0]                 rq_r_ready_i;
    logic [DataWidth-1:0]       rq_r_data_o;
    logic [IdWidth-2:0]         rq_r_id_o;
    logic [1:0]                 rq_r_resp_o;
    logic                       rq_r_last_o;
    logic                       m_ar_valid_o;
    logic                       m_ar_ready_i;
    logic [AddrWidth-1:0]       m_ar_addr_o;
    logic [IdWidth-1:0]         m_ar_id_o;
    logic [7:0]                 m_ar_len_o;
    logic                       m_r_valid_i;
    logic                       m_r_ready_o;
    logic [DataWidth-1:0]       m_r_data_i;
    logic [IdWidth-1:0]         m_r_id_i;
    logic [1:0]                 m_r_resp_i;
    logic                       m_r_last_i;

    modport slave (
        input  rq_ar_valid_i, rq_ar_addr_i, rq_ar_id_i, rq_ar_len_i, rq_r_ready_i,
        input  m_ar_ready_i, m_r_valid_i, m_r_data_i, m_r_id_i, m_r_resp_i, m_r_last_i,
        output rq_ar_ready_o, rq_r_valid_o, rq_r_data_o, rq_r_id_o, rq_r_resp_o, rq_r_last_o,
        output m_ar_valid_o, m_ar_addr_o, m_ar_id_o, m_ar_len_o, m_r_ready_o
    );

    modport master (
        output rq_ar_valid_i, rq_ar_addr_i, rq_ar_id_i, rq_ar_len_i, rq_r_ready_i,
        output m_ar_ready_i, m_r_valid_i, m_r_data_i, m_r_id_i, m_r_resp_i, m_r_last_i,
        input  rq_ar_ready_o, rq_r_valid_o, rq_r_data_o, rq_r_id_o, rq_r_resp_o, rq_r_last_o,
        input  m_ar_valid_o, m_ar_addr_o, m_ar_id_o, m_ar_len_o, m_r_ready_o
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI4 read arbiter (0 = icache refill, 1 = dcache miss).
//
// Round-robin AR grant onto one master AR channel with zero added latency;
// the MSB of m_ar_id_o carries the requester index, and R beats are routed
// back by that bit. Outstanding bursts are counted per requester so a
// requester at MaxOutstanding is not granted.
//
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   bus           axi_rd_arbiter_if.slave (requester AR/R, master AR/R)
//   quiesce_i     stop granting new ARs (a held AR still completes)
//   idle_o        registered: no burst outstanding and no AR pending
//   err_o         sticky: R-last arrived for a requester with nothing in flight
module axi_rd_arbiter #(
    parameter int AddrWidth      = 64,
    parameter int IdWidth        = 4,
    parameter int DataWidth      = 64,
    parameter int MaxOutstanding = 7
) (
    input  logic            clk_i,
    input  logic            rst_i,
    axi_rd_arbiter_if.slave bus,
    input  logic            quiesce_i,
    output logic            idle_o,
    output logic            err_o
);
    localparam int CntWidth  = $clog2(MaxOutstanding + 1);
    localparam int RqIdWidth = IdWidth - 1;
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

    typedef enum logic {ARB = 1'b0, HOLD = 1'b1} state_e;

    state_e                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  grant_q, grant_d;
    logic [CntWidth-1:0]   cnt0_q, cnt1_q;
    logic                  err_q, idle_q;

    logic [1:0]            elig;
    logic                  winner, ar_valid, ar_hs;
    logic                  r_sel, r_last_hs;
    logic                  inc0, inc1, dec0, dec1;
    logic [RqIdWidth-1:0]  rq_id0, rq_id1;
    logic [DataWidth-1:0]  r_data;

    // Saturating outstanding-burst counter; simultaneous inc and dec cancel.
    function automatic logic [CntWidth-1:0] sat_count(input logic [CntWidth-1:0] cnt,
                                                      input logic inc, input logic dec);
        logic [CntWidth-1:0] res;
        res = cnt;
        if (inc && !dec) begin
            if (cnt != CntMax) res = cnt + 1'b1;
        end else if (dec && !inc) begin
            if (cnt != '0) res = cnt - 1'b1;
        end
        return res;
    endfunction

    assign elig[0] = bus.rq_ar_valid_i[0] && (cnt0_q < CntMax) && !quiesce_i;
    assign elig[1] = bus.rq_ar_valid_i[1] && (cnt1_q < CntMax) && !quiesce_i;

    assign rq_id0 = bus.rq_ar_id_i[RqIdWidth-1:0];
    assign rq_id1 = bus.rq_ar_id_i[2*RqIdWidth-1:RqIdWidth];

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        winner       = grant_q;
        ar_valid     = 1'b0;
        unique case (state_q)
            ARB: begin
                // Tie goes to whichever requester was not granted last.
                if (elig == 2'b11) winner = ~last_grant_q;
                else               winner = elig[1];
                ar_valid = |elig;
                if (ar_valid) begin
                    if (bus.m_ar_ready_i) begin
                        last_grant_d = winner;
                    end else begin
                        state_d = HOLD;
                        grant_d = winner;
                    end
                end
            end
            HOLD: begin
                // Committed to grant_q until the handshake so AR valid/payload
                // stay stable; quiesce and the other requester are ignored.
                winner   = grant_q;
                ar_valid = 1'b1;
                if (bus.m_ar_ready_i) begin
                    state_d      = ARB;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = ARB;
        endcase
        if (rst_i) ar_valid = 1'b0;
    end

    assign ar_hs = ar_valid && bus.m_ar_ready_i;
    assign inc0  = ar_hs && !winner;
    assign inc1  = ar_hs && winner;

    assign bus.m_ar_valid_o  = ar_valid;
    assign bus.m_ar_addr_o   = winner ? bus.rq_ar_addr_i[2*AddrWidth-1:AddrWidth]
                                      : bus.rq_ar_addr_i[AddrWidth-1:0];
    assign bus.m_ar_id_o     = {winner, winner ? rq_id1 : rq_id0};
    assign bus.m_ar_len_o    = winner ? bus.rq_ar_len_i[15:8] : bus.rq_ar_len_i[7:0];
    assign bus.rq_ar_ready_o = {inc1, inc0};

    // R path is pure steering on the requester bit of the returned ID.
    assign r_sel             = bus.m_r_id_i[IdWidth-1];
    assign bus.rq_r_valid_o  = {bus.m_r_valid_i && r_sel && !rst_i,
                                bus.m_r_valid_i && !r_sel && !rst_i};
    assign bus.m_r_ready_o   = bus.rq_r_ready_i[r_sel];
    assign r_data            = bus.m_r_data_i;
    assign bus.rq_r_data_o   = r_data;
    assign bus.rq_r_id_o     = bus.m_r_id_i[IdWidth-2:0];
    assign bus.rq_r_resp_o   = bus.m_r_resp_i;
    assign bus.rq_r_last_o   = bus.m_r_last_i;

    assign r_last_hs = bus.m_r_valid_i && bus.m_r_ready_o && bus.m_r_last_i && !rst_i;
    assign dec0      = r_last_hs && !r_sel;
    assign dec1      = r_last_hs && r_sel;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ARB;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
            err_q        <= 1'b0;
            idle_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cnt0_q       <= sat_count(cnt0_q, inc0, dec0);
            cnt1_q       <= sat_count(cnt1_q, inc1, dec1);
            // A last beat with nothing in flight is a protocol violation.
            if ((dec0 && cnt0_q == '0) || (dec1 && cnt1_q == '0)) err_q <= 1'b1;
            idle_q       <= (state_q == ARB) && (cnt0_q == '0) && (cnt1_q == '0) && !ar_valid;
        end
    end

    assign idle_o = idle_q;
    assign err_o  = err_q;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Testbench for axi_rd_arbiter: randomized requesters and R traffic, with a
// scoreboard of issued ARs/R beats and a cycle-level rule model of the grant,
// counters, idle and error flags.
module tb_axi_rd_arbiter;
    localparam int AW   = 64;
    localparam int IW   = 4;
    localparam int DW   = 64;
    localparam int MAXO = 7;

    typedef struct packed {logic [AW-1:0] addr; logic [IW-2:0] id; logic [7:0] len;} ar_t;
    typedef struct packed {logic [IW-1:0] id; logic [7:0] len;} burst_t;
    typedef struct packed {logic [DW-1:0] data; logic [IW-1:0] id; logic [1:0] resp; logic last;} rb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic quiesce = 1'b0;
    logic idle, err;

    logic [1:0]     ar_valid = '0;
    logic [AW-1:0]  ar_addr [2];
    logic [IW-2:0]  ar_id [2];
    logic [7:0]     ar_len [2];
    logic           m_ar_ready = 1'b0;
    logic [1:0]     r_ready = '0;
    logic           m_r_valid = 1'b0;
    logic [DW-1:0]  m_r_data = '0;
    logic [IW-1:0]  m_r_id = '0;
    logic [1:0]     m_r_resp = '0;
    logic           m_r_last = 1'b0;

    axi_rd_arbiter_if #(.AddrWidth(AW), .IdWidth(IW), .DataWidth(DW)) bus ();

    assign bus.rq_ar_valid_i = ar_valid;
    assign bus.rq_ar_addr_i  = {ar_addr[1], ar_addr[0]};
    assign bus.rq_ar_id_i    = {ar_id[1], ar_id[0]};
    assign bus.rq_ar_len_i   = {ar_len[1], ar_len[0]};
    assign bus.rq_r_ready_i  = r_ready;
    assign bus.m_ar_ready_i  = m_ar_ready;
    assign bus.m_r_valid_i   = m_r_valid;
    assign bus.m_r_data_i    = m_r_data;
    assign bus.m_r_id_i      = m_r_id;
    assign bus.m_r_resp_i    = m_r_resp;
    assign bus.m_r_last_i    = m_r_last;

    axi_rd_arbiter #(.AddrWidth(AW), .IdWidth(IW), .DataWidth(DW), .MaxOutstanding(MAXO)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (bus),
        .quiesce_i (quiesce),
        .idle_o    (idle),
        .err_o     (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Scoreboards and reference-model state
    ar_t    ar_sb0[$], ar_sb1[$];
    burst_t out0[$], out1[$];
    rb_t    r_sb[$];
    int     grant_log[$];
    int     mcnt[2] = '{0, 0};
    int     ar_obs[2] = '{0, 0};
    bit     mlast = 1'b1, mhold = 1'b0, mgrant = 1'b0, merr = 1'b0, mexp_idle = 1'b1;
    bit     ar_done[2] = '{0, 0};
    bit     r_done = 1'b0;

    // Stimulus controls
    bit     ar_en[2] = '{0, 0};
    bit     pend[2] = '{0, 0};
    int     gap[2] = '{0, 0};
    int     gap_max = 0;
    bit     r_en = 1'b0, r_active = 1'b0, rnd_mode = 1'b0;
    int     beats_left = 0;
    logic [IW-1:0] cur_id = '0;

    // Monitor: compares outputs with the rule model and pops scoreboards
    always @(negedge clk) begin : monitor
        logic [1:0] elig;
        logic exp_v, w, sel, ar_hs, r_hs, idle_now, have;
        logic [1:0] inc, dec;
        ar_t exp_ar;
        rb_t exp_r;
        burst_t b;
        if (rst) begin
            chk("rst_m_ar_valid", bus.m_ar_valid_o, 0);
            chk("rst_rq_ar_ready", bus.rq_ar_ready_o, 0);
            chk("rst_rq_r_valid", bus.rq_r_valid_o, 0);
            mcnt[0] = 0; mcnt[1] = 0;
            mlast = 1'b1; mhold = 1'b0; mgrant = 1'b0; merr = 1'b0; mexp_idle = 1'b1;
        end else begin
            chk("idle_o", idle, mexp_idle);
            chk("err_o", err, merr);
            for (int i = 0; i < 2; i++) elig[i] = ar_valid[i] && (mcnt[i] < MAXO) && !quiesce;
            exp_v = 1'b1; w = 1'b0;
            if (mhold)              w = mgrant;
            else if (elig == 2'b11) w = !mlast;
            else if (elig == 2'b10) w = 1'b1;
            else if (elig == 2'b01) w = 1'b0;
            else                    exp_v = 1'b0;
            chk("m_ar_valid", bus.m_ar_valid_o, exp_v);
            chk("rq_ar_ready", bus.rq_ar_ready_o, (exp_v && m_ar_ready) ? (w ? 2'b10 : 2'b01) : 2'b00);
            if (exp_v) begin
                chk("m_ar_id", bus.m_ar_id_o, {w, ar_id[w]});
                chk("m_ar_addr", bus.m_ar_addr_o, ar_addr[w]);
                chk("m_ar_len", bus.m_ar_len_o, ar_len[w]);
            end
            ar_hs = exp_v && m_ar_ready;
            idle_now = !mhold && (mcnt[0] == 0) && (mcnt[1] == 0) && !exp_v;
            inc = 2'b00; dec = 2'b00;
            if (ar_hs) begin
                have = 1'b0;
                if (w && ar_sb1.size() != 0) begin exp_ar = ar_sb1.pop_front(); have = 1'b1; end
                if (!w && ar_sb0.size() != 0) begin exp_ar = ar_sb0.pop_front(); have = 1'b1; end
                if (!have) begin
                    checks++; errors++;
                    $display("FAIL ar_scoreboard: actual handshake for requester %0d required none", w);
                end else begin
                    chk("sb_ar_addr", bus.m_ar_addr_o, exp_ar.addr);
                    chk("sb_ar_id", bus.m_ar_id_o, {w, exp_ar.id});
                    chk("sb_ar_len", bus.m_ar_len_o, exp_ar.len);
                    b.id = {w, exp_ar.id}; b.len = exp_ar.len;
                    if (w) out1.push_back(b); else out0.push_back(b);
                end
                ar_done[w] = 1'b1; ar_obs[w]++; grant_log.push_back(int'(w));
                inc[w] = 1'b1; mlast = w; mhold = 1'b0;
            end else if (exp_v) begin
                mhold = 1'b1; mgrant = w;
            end
            sel = m_r_id[IW-1];
            chk("rq_r_valid", bus.rq_r_valid_o, m_r_valid ? (sel ? 2'b10 : 2'b01) : 2'b00);
            if (m_r_valid) chk("m_r_ready", bus.m_r_ready_o, r_ready[sel]);
            r_hs = m_r_valid && r_ready[sel];
            if (r_hs) begin
                if (r_sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL r_scoreboard: actual unexpected beat required none");
                end else begin
                    exp_r = r_sb.pop_front();
                    chk("rq_r_data", bus.rq_r_data_o, exp_r.data);
                    chk("rq_r_id", bus.rq_r_id_o, exp_r.id[IW-2:0]);
                    chk("rq_r_resp", bus.rq_r_resp_o, exp_r.resp);
                    chk("rq_r_last", bus.rq_r_last_o, exp_r.last);
                end
                r_done = 1'b1;
                if (m_r_last) dec[sel] = 1'b1;
            end
            for (int i = 0; i < 2; i++) begin
                if (dec[i] && mcnt[i] == 0) merr = 1'b1;
                if (inc[i] && !dec[i] && mcnt[i] < MAXO) mcnt[i]++;
                else if (dec[i] && !inc[i] && mcnt[i] > 0) mcnt[i]--;
            end
            mexp_idle = idle_now;
        end
    end

    // Requester AR drivers: present a request, hold it until accepted
    always @(posedge clk) begin : ar_driver
        ar_t req;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (pend[i] && ar_done[i]) begin
                pend[i] = 1'b0; ar_done[i] = 1'b0; ar_valid[i] = 1'b0;
                gap[i] = (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0));
            end
            if (!pend[i] && ar_en[i] && !rst) begin
                if (gap[i] > 0) begin
                    gap[i]--;
                end else begin
                    req.addr = {$urandom, $urandom};
                    req.id   = (IW-1)'($urandom);
                    req.len  = 8'($urandom_range(3, 0));
                    ar_addr[i] = req.addr; ar_id[i] = req.id; ar_len[i] = req.len;
                    ar_valid[i] = 1'b1; pend[i] = 1'b1;
                    if (i == 0) ar_sb0.push_back(req); else ar_sb1.push_back(req);
                end
            end
        end
    end

    task automatic present_beat();
        rb_t beat;
        beat.data = {$urandom, $urandom};
        beat.id   = cur_id;
        beat.resp = 2'($urandom);
        beat.last = (beats_left == 0);
        m_r_data = beat.data; m_r_id = beat.id; m_r_resp = beat.resp; m_r_last = beat.last;
        m_r_valid = 1'b1;
        r_sb.push_back(beat);
    endtask

    // R driver: returns accepted bursts, one at a time
    always @(posedge clk) begin : r_driver
        burst_t b;
        int pick;
        #1;
        if (r_active && r_done) begin
            r_done = 1'b0;
            if (beats_left == 0) begin
                r_active = 1'b0; m_r_valid = 1'b0;
            end else begin
                beats_left--; present_beat();
            end
        end
        if (!r_active && r_en && !rst) begin
            pick = -1;
            if (out0.size() != 0 && out1.size() != 0) pick = int'($urandom_range(1, 0));
            else if (out0.size() != 0) pick = 0;
            else if (out1.size() != 0) pick = 1;
            if (pick >= 0) begin
                if (pick == 1) b = out1.pop_front(); else b = out0.pop_front();
                cur_id = b.id; beats_left = int'(b.len); r_active = 1'b1;
                present_beat();
            end
        end
    end

    // Random ready/quiesce pressure
    always @(posedge clk) begin : rnd_ready
        #1;
        if (rnd_mode) begin
            m_ar_ready = 1'($urandom);
            r_ready    = 2'($urandom);
            if ($urandom_range(29, 0) == 0) quiesce = !quiesce;
        end
    end

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((ar_sb0.size() + ar_sb1.size() + out0.size() + out1.size() + r_sb.size()) != 0 ||
               r_active || pend[0] || pend[1] || mcnt[0] != 0 || mcnt[1] != 0) begin
            @(negedge clk);
            n++;
            if (n > limit) begin
                checks++; errors++;
                $display("FAIL drain_timeout: actual still busy after %0d cycles required idle", limit);
                break;
            end
        end
        repeat (3) @(negedge clk);
        chk("drain_idle", idle, 1);
    endtask

    int exp_seq[4] = '{0, 1, 0, 1};

    initial begin
        ar_addr[0] = '0; ar_addr[1] = '0; ar_id[0] = '0; ar_id[1] = '0; ar_len[0] = '0; ar_len[1] = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_idle", idle, 1);
        chk("reset_err", err, 0);
        chk("reset_ar_ready", bus.rq_ar_ready_o, 0);
        chk("reset_r_valid", bus.rq_r_valid_o, 0);

        // Both requesters always valid, master always ready, no R returned
        gap_max = 0; m_ar_ready = 1'b1; r_ready = 2'b11;
        ar_en[0] = 1'b1; ar_en[1] = 1'b1;
        repeat (25) @(negedge clk);
        for (int i = 0; i < 4; i++)
            chk("rr_grant", (grant_log.size() > i) ? grant_log[i] : 99, exp_seq[i]);
        chk("sat_cnt0", ar_obs[0], MAXO);
        chk("sat_cnt1", ar_obs[1], MAXO);
        chk("sat_blocked_valid", bus.m_ar_valid_o, 0);
        chk("sat_blocked_ready", bus.rq_ar_ready_o, 0);
        ar_en[0] = 1'b0; ar_en[1] = 1'b0;
        r_en = 1'b1;
        drain(2000);
        chk("sat_released", ar_obs[0] + ar_obs[1], 2 * MAXO + 2);

        // Randomized traffic with backpressure and quiesce
        gap_max = 4; rnd_mode = 1'b1;
        ar_en[0] = 1'b1; ar_en[1] = 1'b1;
        repeat (3000) @(negedge clk);
        ar_en[0] = 1'b0; ar_en[1] = 1'b0;
        rnd_mode = 1'b0; quiesce = 1'b0; m_ar_ready = 1'b1; r_ready = 2'b11;
        drain(3000);

        // Routing of ID 4'b1011, then a stray last beat for requester 0
        r_en = 1'b0;
        @(posedge clk); #1;
        cur_id = 4'b1011; beats_left = 1; r_ready = 2'b10;
        present_beat();
        @(negedge clk);
        chk("r_route_valid", bus.rq_r_valid_o, 2'b10);
        chk("r_route_id", bus.rq_r_id_o, 3'b011);
        @(posedge clk); #1;
        cur_id = 4'b0101; beats_left = 0; r_ready = 2'b01;
        present_beat();
        @(posedge clk); #1;
        m_r_valid = 1'b0; r_done = 1'b0;
        @(negedge clk);
        chk("err_set", err, 1);
        repeat (4) @(negedge clk);
        chk("err_sticky", err, 1);

        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("err_cleared", err, 0);
        chk("idle_after_reset", idle, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
